key_seq_driver: RTL
===================

KEY_SEQ_DRIVER -- requirements
Module: key_seq_driver

Interface
REQ-001 Parameter INPUT_LEN, default 4: width of one key word, equal to the locked circuit's primary-input width.
REQ-002 Parameter SEQ_LEN, default 4: number of key words per unlock sequence.
REQ-003 Parameter KEY, default 16'h3A5C: packed key, SEQ_LEN*INPUT_LEN bits; word i = KEY[i*INPUT_LEN +: INPUT_LEN].
REQ-004 Parameter DEADLINE, default 5: maximum cycles to wait for acknowledge after the last key word.
REQ-005 Parameter MAX_RETRY, default 3: total sequence attempts before failure.
REQ-006 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-007 Port reset, input, 1: reset is asynchronous and active-high.
REQ-008 Port start, input, 1: request to issue the unlock sequence; sampled only in IDLE.
REQ-009 Port abort, input, 1: cancel any operation in progress.
REQ-010 Port user_in, input, INPUT_LEN: functional inputs passed through when not driving a key.
REQ-011 Port ack, input, 1: locked circuit reports normal mode restored (comparator match).
REQ-012 Port circ_in, output, INPUT_LEN: vector driven onto the locked circuit's primary inputs.
REQ-013 Port busy, output, 1: high in DRIVE, WAIT_ACK and DONE.
REQ-014 Port done, output, 1: one-cycle pulse on successful unlock.
REQ-015 Port fail, output, 1: sticky flag after MAX_RETRY attempts without ack.
REQ-016 Port seq_idx, output, clog2(SEQ_LEN) bits (min 1): index of the key word currently driven.

Function
REQ-017 States SHALL be IDLE, DRIVE, WAIT_ACK, DONE, FAIL.
REQ-018 circ_in SHALL be decoded from registered state only: IDLE/FAIL -> user_in; DRIVE -> KEY word seq_idx; WAIT_ACK/DONE -> all zeros.
REQ-019 IDLE with start=1, abort=0 -> DRIVE next cycle, seq_idx=0, retry count=0, fail cleared.
REQ-020 DRIVE SHALL last exactly SEQ_LEN cycles, seq_idx incrementing by one per cycle, then -> WAIT_ACK with wait count 0.
REQ-021 ack SHALL be ignored outside WAIT_ACK.
REQ-022 WAIT_ACK with ack=1 in any cycle -> DONE next cycle.
REQ-023 WAIT_ACK with no ack in wait count DEADLINE-1 -> retry count+1; if new count < MAX_RETRY -> DRIVE with seq_idx=0, else -> FAIL.
REQ-024 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-025 FAIL SHALL hold fail=1, behave as IDLE for start (start -> DRIVE, fail cleared).
REQ-026 abort=1 in any state -> IDLE next cycle, fail unchanged, no done pulse; abort wins over simultaneous start or ack.
REQ-027 start while busy SHALL be ignored.
REQ-028 Wait and retry counters SHALL be sized clog2(DEADLINE+1) and clog2(MAX_RETRY+1) and SHALL never wrap.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, seq_idx=0, counters=0, busy=0, done=0, fail=0, circ_in=user_in, including mid-sequence.
REQ-030 First state change after reset deassertion SHALL occur on a clk edge with reset low.

Structure
REQ-031 State encoding and default parameter values SHALL live in shared package key_seq_pkg.
REQ-032 Wait-count and expiry logic SHALL be sub-module seq_deadline_timer (inputs clear, enable; output expired).
REQ-033 Implementation SHALL be 120-400 lines RTL, no latches, no combinational loops through ack.

Verification
REQ-034 Defaults, start pulse, ack on 2nd WAIT_ACK cycle -> circ_in = C,5,A,3 on four consecutive cycles, then 0,0, done pulse next cycle, busy low after.
REQ-035 Defaults, ack never -> three full sequences (each 4 drive + 5 wait cycles), then fail=1, circ_in=user_in.
REQ-036 abort in 3rd DRIVE cycle (seq_idx=2) -> IDLE next cycle, circ_in=user_in, done=0, fail=0.
REQ-037 reset asserted mid-WAIT_ACK (between edges) -> outputs at reset values immediately, restart by start works.
REQ-038 ack pulsed during DRIVE, start re-pulsed while busy -> both ignored; sequence and timing unchanged.
REQ-039 From FAIL, start with ack in 1st WAIT_ACK cycle -> fail cleared on entry to DRIVE, done pulse 6 cycles after start sampled.

Source files
------------

// File: rtl/key_seq_pkg.sv
// Shared state encoding and default parameters for the key-sequence unlock driver.
package key_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRIVE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAIL     = 3'd4
  } state_e;

  localparam int              DEF_INPUT_LEN = 4;
  localparam int              DEF_SEQ_LEN   = 4;
  localparam int              DEF_DEADLINE  = 5;
  localparam int              DEF_MAX_RETRY = 3;
  localparam logic [15:0]     DEF_KEY       = 16'h3A5C;

endpackage

// File: rtl/seq_deadline_timer.sv
// Counts cycles spent waiting for acknowledge; flags the last permitted cycle.
module seq_deadline_timer #(
  parameter int DEADLINE = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(DEADLINE + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at DEADLINE so the count can never wrap back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && (cnt_q < CNT_W'(DEADLINE)))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = enable && !clear && (cnt_q == CNT_W'(DEADLINE - 1));

endmodule

// File: rtl/key_seq_driver.sv
// Drives a packed unlock key onto a locked circuit's inputs, waits for ack,
// and retries a bounded number of times before raising a sticky fail flag.
module key_seq_driver
  import key_seq_pkg::*;
#(
  parameter int                           INPUT_LEN = DEF_INPUT_LEN,
  parameter int                           SEQ_LEN   = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN*INPUT_LEN-1:0] KEY       = DEF_KEY,
  parameter int                           DEADLINE  = DEF_DEADLINE,
  parameter int                           MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [INPUT_LEN-1:0] user_in,
  input  logic                 ack,
  output logic [INPUT_LEN-1:0] circ_in,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [((SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1)-1:0] seq_idx
);

  localparam int IDX_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_e               state_q;
  logic [IDX_W-1:0]     seq_idx_q;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 done_q, fail_q;
  logic                 tmr_expired;
  logic [INPUT_LEN-1:0] key_word;

  seq_deadline_timer #(.DEADLINE(DEADLINE)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != ST_WAIT_ACK),
    .enable  (state_q == ST_WAIT_ACK),
    .expired (tmr_expired)
  );

  assign retry_d = (retry_q < RETRY_W'(MAX_RETRY)) ? retry_q + RETRY_W'(1) : retry_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      seq_idx_q <= '0;
      retry_q   <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // fail is deliberately left untouched on abort.
        state_q   <= ST_IDLE;
        seq_idx_q <= '0;
        retry_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE, ST_FAIL: begin
            if (start) begin
              state_q   <= ST_DRIVE;
              seq_idx_q <= '0;
              retry_q   <= '0;
              fail_q    <= 1'b0;
            end
          end
          ST_DRIVE: begin
            if (seq_idx_q == IDX_W'(SEQ_LEN - 1))
              state_q <= ST_WAIT_ACK;
            else
              seq_idx_q <= seq_idx_q + IDX_W'(1);
          end
          ST_WAIT_ACK: begin
            if (ack) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (tmr_expired) begin
              retry_q <= retry_d;
              if (retry_d < RETRY_W'(MAX_RETRY)) begin
                state_q   <= ST_DRIVE;
                seq_idx_q <= '0;
              end else begin
                state_q <= ST_FAIL;
                fail_q  <= 1'b1;
              end
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    key_word = '0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (seq_idx_q == IDX_W'(i)) key_word = KEY[i*INPUT_LEN +: INPUT_LEN];
  end

  // Key material only reaches the circuit while the registered state is DRIVE.
  always_comb begin
    circ_in = user_in;
    case (state_q)
      ST_DRIVE:             circ_in = key_word;
      ST_WAIT_ACK, ST_DONE: circ_in = '0;
      default:              circ_in = user_in;
    endcase
  end

  assign busy    = (state_q == ST_DRIVE) || (state_q == ST_WAIT_ACK) || (state_q == ST_DONE);
  assign done    = done_q;
  assign fail    = fail_q;
  assign seq_idx = seq_idx_q;

endmodule
